// File: rtl/ddr_cmd_responder.sv
`timescale 1ns/1ps
// ddr_cmd_responder
//   Behavioural DDR device command responder. Decodes the command pins
//   every clock, tracks per-bank open/row state, runs a single read or
//   write burst of 4 beats at a time, and keeps a small 16-bit storage
//   array of 8 banks x 2^COL_BITS words.
//
// Ports
//   CLK            rising-edge clock
//   RESET          asynchronous active-high reset
//   CS,RAS,CAS,WE  active-low command pins
//   Addr[14:0]     row on ACT, column in [COL_BITS-1:0], A10 flag
//   BA[2:0]        bank address
//   LDM,UDM        write byte masks (1 = byte not written)
//   DQ[15:0]       bidirectional data
//   LDQS,UDQS      read strobes (driven only during preamble/beats)
//   bank_open[7:0] per-bank open flags
//   open_row[14:0] latched row of the bank addressed by BA
//   cmd_err        sticky protocol error flag
//   busy           a burst is scheduled or in progress
//
// Timing, for a command on edge E0:
//   write beats are sampled on edges E0+CWL .. E0+CWL+3
//   read preamble is driven from E0+CL-1, beats from E0+CL .. E0+CL+3,
//   and the bus is released at E0+CL+4.
// CL and CWL must be at least 2; COL_BITS must be at least 2.
module ddr_cmd_responder #(
  parameter int CL       = 5,
  parameter int CWL      = 5,
  parameter int COL_BITS = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CS,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WE,
  input  logic [14:0] Addr,
  input  logic [2:0]  BA,
  input  logic        LDM,
  input  logic        UDM,
  inout  wire  [15:0] DQ,
  inout  wire         LDQS,
  inout  wire         UDQS,
  output logic [7:0]  bank_open,
  output logic [14:0] open_row,
  output logic        cmd_err,
  output logic        busy
);

  localparam int AW    = 3 + COL_BITS;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLAT,
    S_WBURST,
    S_RLAT,
    S_RBURST
  } state_t;

  state_t              state_q;
  logic [7:0]          lat_q;
  logic [1:0]          beat_q;
  logic [2:0]          bank_q;
  logic [COL_BITS-1:0] col_q;
  logic                ap_q;
  logic                ap_pend_q;
  logic [2:0]          ap_bank_q;
  logic [14:0]         row_q [8];

  logic                dq_oe_q;
  logic                dqs_oe_q;
  logic                dqs_q;
  logic [15:0]         dq_out_q;

  logic [15:0]         mem [DEPTH];

  // Command decode
  logic [3:0] cmd;
  logic       cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref;
  logic       rw_ok;

  assign cmd     = {CS, RAS, CAS, WE};
  assign cmd_act = (cmd == 4'b0011);
  assign cmd_rd  = (cmd == 4'b0101);
  assign cmd_wr  = (cmd == 4'b0100);
  assign cmd_pre = (cmd == 4'b0010);
  assign cmd_ref = (cmd == 4'b0001);
  // MRS (0000), ZQCL (0110) and NOPs fall through with no effect.

  assign rw_ok = bank_open[BA] && (state_q == S_IDLE);

  // Beat address: low two column bits wrap inside the aligned group of 4.
  logic [COL_BITS-1:0] beat_col;
  logic [AW-1:0]       beat_addr;

  always_comb begin
    beat_col      = col_q;
    beat_col[1:0] = col_q[1:0] + beat_q;
  end

  assign beat_addr = {bank_q, beat_col};

  // Control, bank state and FSM
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      lat_q     <= '0;
      beat_q    <= '0;
      bank_q    <= '0;
      col_q     <= '0;
      ap_q      <= 1'b0;
      ap_pend_q <= 1'b0;
      ap_bank_q <= '0;
      bank_open <= '0;
      cmd_err   <= 1'b0;
      dq_oe_q   <= 1'b0;
      dqs_oe_q  <= 1'b0;
      dqs_q     <= 1'b0;
      for (int i = 0; i < 8; i++) row_q[i] <= '0;
    end else begin
      dq_oe_q  <= 1'b0;
      dqs_oe_q <= 1'b0;
      dqs_q    <= 1'b0;

      // Auto-precharge lands one cycle after the last beat; a command on
      // the same edge is applied afterwards and therefore takes priority.
      if (ap_pend_q) begin
        bank_open[ap_bank_q] <= 1'b0;
        ap_pend_q            <= 1'b0;
      end

      if (cmd_act) begin
        if (bank_open[BA]) begin
          cmd_err <= 1'b1;
        end else begin
          bank_open[BA] <= 1'b1;
          row_q[BA]     <= Addr;
        end
      end

      if (cmd_pre) begin
        if (Addr[10]) bank_open <= '0;
        else          bank_open[BA] <= 1'b0;
      end

      if (cmd_ref && (|bank_open)) cmd_err <= 1'b1;

      if ((cmd_rd || cmd_wr) && !rw_ok) cmd_err <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if ((cmd_rd || cmd_wr) && rw_ok) begin
            state_q <= cmd_wr ? S_WLAT : S_RLAT;
            lat_q   <= cmd_wr ? 8'(CWL - 2) : 8'(CL - 2);
            beat_q  <= '0;
            bank_q  <= BA;
            col_q   <= Addr[COL_BITS-1:0];
            ap_q    <= Addr[10];
          end
        end
        S_WLAT: begin
          if (lat_q == 8'd0) state_q <= S_WBURST;
          else               lat_q   <= lat_q - 8'd1;
        end
        S_RLAT: begin
          if (lat_q == 8'd0) begin
            state_q  <= S_RBURST;
            dqs_oe_q <= 1'b1;      // preamble: strobes low one cycle early
          end else begin
            lat_q <= lat_q - 8'd1;
          end
        end
        S_WBURST, S_RBURST: begin
          if (state_q == S_RBURST) begin
            dq_oe_q  <= 1'b1;
            dqs_oe_q <= 1'b1;
            dqs_q    <= ~beat_q[0];
          end
          beat_q <= beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_q   <= S_IDLE;
            ap_pend_q <= ap_q;
            ap_bank_q <= bank_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Storage: not reset. Writes only happen in WBURST, which reset leaves
  // immediately, so an aborted burst never writes its remaining beats.
  always_ff @(posedge CLK) begin
    if (state_q == S_WBURST) begin
      if (!LDM) mem[beat_addr][7:0]  <= DQ[7:0];
      if (!UDM) mem[beat_addr][15:8] <= DQ[15:8];
    end
    if (state_q == S_RBURST) dq_out_q <= mem[beat_addr];
  end

  assign DQ       = dq_oe_q  ? dq_out_q : 16'bz;
  assign LDQS     = dqs_oe_q ? dqs_q    : 1'bz;
  assign UDQS     = dqs_oe_q ? dqs_q    : 1'bz;
  assign open_row = row_q[BA];
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ddr_cmd_responder.sv
`timescale 1ns/1ps
module tb_ddr_cmd_responder;
  localparam int CL = 5, CWL = 5, COL_BITS = 3;
  localparam int NW = 8 << COL_BITS;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101,
                         C_WR = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001,
                         C_MRS = 4'b0000, C_ZQ = 4'b0110;
  localparam logic [15:0] HZ16 = 16'hFFFF;  // released bus reads as pulled-up

  logic CLK = 1'b0, RESET = 1'b0;
  logic CS = 1'b1, RAS = 1'b1, CAS = 1'b1, WE = 1'b1;
  logic [14:0] Addr = '0;
  logic [2:0]  BA = '0;
  logic LDM = 1'b0, UDM = 1'b0;
  tri1 [15:0] DQ;
  tri1 LDQS, UDQS;
  logic [7:0]  bank_open;
  logic [14:0] open_row;
  logic cmd_err, busy;
  logic [15:0] dq_drv = '0;
  logic dq_oe = 1'b0;

  assign DQ = dq_oe ? dq_drv : 16'bz;

  ddr_cmd_responder #(.CL(CL), .CWL(CWL), .COL_BITS(COL_BITS)) dut (
    .CLK(CLK), .RESET(RESET), .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE),
    .Addr(Addr), .BA(BA), .LDM(LDM), .UDM(UDM), .DQ(DQ), .LDQS(LDQS),
    .UDQS(UDQS), .bank_open(bank_open), .open_row(open_row),
    .cmd_err(cmd_err), .busy(busy));

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;

  // Reference model
  logic [15:0] mdl_mem [NW];
  logic [7:0]  mdl_open = '0;
  logic [14:0] mdl_row [8];
  logic        mdl_err = 1'b0;

  function automatic int maddr(input int ba, input int col, input int b);
    return ba * (1 << COL_BITS) + (col & ~3) + ((col + b) % 4);
  endfunction

  function automatic void model_cmd(input logic [3:0] c, input logic [2:0] ba, input logic [14:0] a);
    case (c)
      C_ACT: if (mdl_open[ba]) mdl_err = 1'b1; else begin mdl_open[ba] = 1'b1; mdl_row[ba] = a; end
      C_PRE: if (a[10]) mdl_open = '0; else mdl_open[ba] = 1'b0;
      C_REF: if (|mdl_open) mdl_err = 1'b1;
      C_RD, C_WR: mdl_err = 1'b1;  // only injected while a burst is running
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    mdl_open = '0;
    mdl_err  = 1'b0;
    for (int i = 0; i < 8; i++) mdl_row[i] = '0;
  endfunction

  task automatic idle_pins();
    {CS, RAS, CAS, WE} = C_NOP; BA = '0; Addr = '0; LDM = 1'b0; UDM = 1'b0;
  endtask

  task automatic drive_noise();
    int r;
    r = $urandom_range(0, 3);
    case (r)
      0: {CS, RAS, CAS, WE} = {1'b1, 3'($urandom)};
      1: {CS, RAS, CAS, WE} = C_NOP;
      2: {CS, RAS, CAS, WE} = C_MRS;
      default: {CS, RAS, CAS, WE} = C_ZQ;
    endcase
    BA = 3'($urandom); Addr = 15'($urandom);
    LDM = 1'($urandom); UDM = 1'($urandom);
  endtask

  task automatic send(input logic [3:0] c, input logic [2:0] ba, input logic [14:0] a);
    @(negedge CLK);
    {CS, RAS, CAS, WE} = c; BA = ba; Addr = a;
    @(posedge CLK);
    #1 idle_pins();
  endtask

  task automatic cmd(input logic [3:0] c, input logic [2:0] ba, input logic [14:0] a);
    send(c, ba, a);
    model_cmd(c, ba, a);
  endtask

  task automatic reset_dut();
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    model_reset();
  endtask

  task automatic do_write(input logic [2:0] ba, input int col, input bit a10,
                          input logic [63:0] data, input logic [7:0] mask, input bit noise,
                          input int inj_k, input logic [3:0] inj_c, input logic [2:0] inj_ba,
                          input logic [14:0] inj_a);
    bit acc;
    int b;
    acc = mdl_open[ba];
    if (!acc) mdl_err = 1'b1;
    send(C_WR, ba, 15'((a10 ? 1024 : 0) + col));
    for (int k = 1; k <= CWL + 3; k++) begin
      @(negedge CLK);
      if (noise) drive_noise(); else idle_pins();
      if (k == inj_k) begin
        {CS, RAS, CAS, WE} = inj_c; BA = inj_ba; Addr = inj_a;
        model_cmd(inj_c, inj_ba, inj_a);
      end
      if (k >= CWL) begin
        b = k - CWL;
        dq_drv = data[b*16 +: 16]; dq_oe = 1'b1;
        LDM = mask[b*2]; UDM = mask[b*2+1];
      end else begin
        dq_oe = 1'b0;
      end
      @(posedge CLK);
    end
    #1 dq_oe = 1'b0; idle_pins();
    if (acc) begin
      for (int i = 0; i < 4; i++) begin
        if (!mask[i*2])   mdl_mem[maddr(ba, col, i)][7:0]  = data[i*16 +: 8];
        if (!mask[i*2+1]) mdl_mem[maddr(ba, col, i)][15:8] = data[i*16+8 +: 8];
      end
      if (a10) mdl_open[ba] = 1'b0;
    end
    checks++;
    if (cmd_err !== mdl_err) begin
      errors++; $display("FAIL write_err ba=%0d col=%0d: cmd_err=%b want %b", ba, col, cmd_err, mdl_err);
    end
    $display("write ba=%0d col=%0d a10=%0d mask=%h acc=%0d", ba, col, a10, mask, acc);
  endtask

  task automatic do_read(input logic [2:0] ba, input int col, input bit a10, input bit noise,
                         input int inj_k, input logic [3:0] inj_c, input logic [2:0] inj_ba,
                         input logic [14:0] inj_a);
    bit acc;
    logic [15:0] exp_dq;
    logic exp_s;
    logic [17:0] got_v;
    acc = mdl_open[ba];
    if (!acc) mdl_err = 1'b1;
    send(C_RD, ba, 15'((a10 ? 1024 : 0) + col));
    for (int k = 1; k <= CL + 4; k++) begin
      @(negedge CLK);
      if (noise) drive_noise(); else idle_pins();
      if (k == inj_k) begin
        {CS, RAS, CAS, WE} = inj_c; BA = inj_ba; Addr = inj_a;
        model_cmd(inj_c, inj_ba, inj_a);
      end
      @(posedge CLK);
      #1;
      if (acc && k >= CL && k <= CL + 3) begin
        exp_dq = mdl_mem[maddr(ba, col, k - CL)];
        exp_s  = ((k - CL) % 2 == 0);
      end else if (acc && k == CL - 1) begin
        exp_dq = HZ16; exp_s = 1'b0;
      end else begin
        exp_dq = HZ16; exp_s = 1'b1;
      end
      got_v = {DQ, LDQS, UDQS};
      checks++;
      if (got_v !== {exp_dq, exp_s, exp_s}) begin
        errors++;
        $display("FAIL read_bus ba=%0d col=%0d +%0d: DQ=%h LDQS=%b UDQS=%b want DQ=%h DQS=%b",
                 ba, col, k, DQ, LDQS, UDQS, exp_dq, exp_s);
      end
      if (!acc || k == 1 || k == CL + 4) begin
        checks++;
        if (busy !== (acc && k == 1)) begin
          errors++; $display("FAIL read_busy +%0d: busy=%b want %b", k, busy, acc && k == 1);
        end
      end
      if (acc && a10 && k == CL + 3) begin
        checks++;
        if (bank_open[ba] !== mdl_open[ba]) begin
          errors++; $display("FAIL ap_before +%0d: bank_open[%0d]=%b want %b", k, ba, bank_open[ba], mdl_open[ba]);
        end
      end
      if (acc && a10 && k == CL + 4) mdl_open[ba] = 1'b0;
    end
    checks++;
    if ({bank_open, cmd_err} !== {mdl_open, mdl_err}) begin
      errors++; $display("FAIL read_state ba=%0d: bank_open=%h cmd_err=%b want %h %b",
                         ba, bank_open, cmd_err, mdl_open, mdl_err);
    end
    $display("read  ba=%0d col=%0d a10=%0d acc=%0d", ba, col, a10, acc);
  endtask

  task automatic wr(input logic [2:0] ba, input int col, input logic [63:0] d, input logic [7:0] m);
    do_write(ba, col, 1'b0, d, m, 1'b0, 0, C_NOP, 3'd0, 15'd0);
  endtask

  task automatic rd(input logic [2:0] ba, input int col, input bit a10);
    do_read(ba, col, a10, 1'b0, 0, C_NOP, 3'd0, 15'd0);
  endtask

  task automatic check_row(input logic [2:0] b);
    @(negedge CLK); BA = b; #1;
    checks++;
    if (open_row !== mdl_row[b]) begin
      errors++; $display("FAIL open_row ba=%0d: %h want %h", b, open_row, mdl_row[b]);
    end
    BA = '0;
  endtask

  task automatic test_reset();
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    model_reset();
    checks++;
    if ({bank_open, open_row, cmd_err, busy} !== {8'h00, 15'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_state: open=%h row=%h err=%b busy=%b want all 0",
                         bank_open, open_row, cmd_err, busy);
    end
    checks++;
    if ({DQ, LDQS, UDQS} !== {HZ16, 2'b11}) begin
      errors++; $display("FAIL reset_bus: DQ=%h LDQS=%b UDQS=%b want released", DQ, LDQS, UDQS);
    end
    @(negedge CLK); RESET = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_basic();
    cmd(C_ACT, 3'd5, 15'd1);
    checks++;
    if (bank_open !== 8'h20) begin
      errors++; $display("FAIL act_open: bank_open=%h want 20", bank_open);
    end
    check_row(3'd5);
    wr(3'd5, 1, {16'h00A4, 16'h00A3, 16'h00A2, 16'h00A1}, 8'h00);
    rd(3'd5, 1, 1'b0);
  endtask

  task automatic test_wrap();
    wr(3'd5, 2, {16'hD003, 16'hD002, 16'hD001, 16'hD000}, 8'h00);
    checks++;
    if (mdl_mem[maddr(5, 0, 0)] !== 16'hD002) begin
      errors++; $display("FAIL wrap_model: addr0=%h want D002", mdl_mem[maddr(5, 0, 0)]);
    end
    rd(3'd5, 0, 1'b0);
  endtask

  task automatic test_mask();
    logic [63:0] d;
    wr(3'd5, 4, {4{16'hFFFF}}, 8'h00);
    d = {$urandom, $urandom};
    wr(3'd5, 4, d, 8'b1010_1010);
    rd(3'd5, 4, 1'b0);
  endtask

  task automatic test_random();
    for (int b = 0; b < 8; b++) if (!mdl_open[b]) cmd(C_ACT, 3'(b), 15'($urandom));
    for (int b = 0; b < 8; b++) check_row(3'(b));
    for (int b = 0; b < 8; b++)
      for (int g = 0; g < (1 << COL_BITS) / 4; g++)
        do_write(3'(b), g * 4 + int'($urandom_range(0, 3)), 1'b0, {$urandom, $urandom}, 8'h00,
                 1'b1, 0, C_NOP, 3'd0, 15'd0);
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(3'($urandom), int'($urandom_range(0, (1 << COL_BITS) - 1)), 1'b0,
                 {$urandom, $urandom}, 8'($urandom), 1'b1, 0, C_NOP, 3'd0, 15'd0);
      else
        do_read(3'($urandom), int'($urandom_range(0, (1 << COL_BITS) - 1)), 1'b0, 1'b1,
                0, C_NOP, 3'd0, 15'd0);
    end
  endtask

  task automatic test_busy_reject();
    reset_dut();
    cmd(C_ACT, 3'd0, 15'h0123);
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++; $display("FAIL busy_pre_err: cmd_err=%b want 0", cmd_err);
    end
    do_read(3'd0, 3, 1'b0, 1'b0, 2, C_WR, 3'd0, 15'd1);
    rd(3'd0, 1, 1'b0);
  endtask

  task automatic test_closed_bank();
    reset_dut();
    rd(3'd3, 2, 1'b0);
    checks++;
    if (cmd_err !== 1'b1) begin
      errors++; $display("FAIL closed_err: cmd_err=%b want 1", cmd_err);
    end
  endtask

  task automatic test_act_ref();
    reset_dut();
    cmd(C_REF, 3'd0, 15'd0);
    cmd(C_PRE, 3'd2, 15'd0);
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++; $display("FAIL ref_idle_err: cmd_err=%b want 0", cmd_err);
    end
    cmd(C_ACT, 3'd5, 15'd7);
    cmd(C_ACT, 3'd5, 15'd9);
    checks++;
    if (cmd_err !== 1'b1) begin
      errors++; $display("FAIL act_open_err: cmd_err=%b want 1", cmd_err);
    end
    check_row(3'd5);
    reset_dut();
    cmd(C_ACT, 3'd1, 15'd3);
    cmd(C_ACT, 3'd2, 15'd4);
    cmd(C_PRE, 3'd1, 15'd0);
    checks++;
    if ({bank_open, cmd_err} !== {8'h04, 1'b0}) begin
      errors++; $display("FAIL pre_one: bank_open=%h err=%b want 04 0", bank_open, cmd_err);
    end
    cmd(C_REF, 3'd0, 15'd0);
    checks++;
    if (cmd_err !== 1'b1) begin
      errors++; $display("FAIL ref_open_err: cmd_err=%b want 1", cmd_err);
    end
    cmd(C_PRE, 3'd6, 15'h0400);
    checks++;
    if (bank_open !== 8'h00) begin
      errors++; $display("FAIL pre_all: bank_open=%h want 00", bank_open);
    end
    $display("act/ref/pre sequence done");
  endtask

  task automatic test_ap_and_reset();
    logic [15:0] d0;
    reset_dut();
    cmd(C_ACT, 3'd6, 15'h1ABC);
    rd(3'd6, 0, 1'b1);
    cmd(C_ACT, 3'd6, 15'h0042);
    cmd(C_ACT, 3'd6, 15'h0043);
    // Reset during beat 1 of a read
    send(C_RD, 3'd6, 15'h0402);
    for (int k = 1; k <= CL + 1; k++) @(posedge CLK);
    #1;
    checks++;
    if (DQ !== mdl_mem[maddr(6, 2, 1)]) begin
      errors++; $display("FAIL mid_read_beat1: DQ=%h want %h", DQ, mdl_mem[maddr(6, 2, 1)]);
    end
    #1 RESET = 1'b1;
    #1;
    checks++;
    if ({DQ, LDQS, UDQS, busy, cmd_err, bank_open} !== {HZ16, 2'b11, 1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL mid_read_reset: DQ=%h LDQS=%b busy=%b err=%b open=%h want released/0",
                         DQ, LDQS, busy, cmd_err, bank_open);
    end
    @(negedge CLK); RESET = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      checks++;
      if ({DQ, LDQS, busy} !== {HZ16, 1'b1, 1'b0}) begin
        errors++; $display("FAIL post_reset_bus: DQ=%h LDQS=%b busy=%b want released", DQ, LDQS, busy);
      end
    end
    // Reset after beat 0 of a write: beats 1-3 must stay unwritten
    cmd(C_ACT, 3'd6, 15'h0005);
    d0 = 16'($urandom);
    send(C_WR, 3'd6, 15'd4);
    for (int k = 1; k <= CWL; k++) begin
      @(negedge CLK);
      if (k == CWL) begin dq_drv = d0; dq_oe = 1'b1; end
      @(posedge CLK);
    end
    #2 RESET = 1'b1;
    for (int b = 1; b < 4; b++) begin
      @(negedge CLK); dq_drv = 16'($urandom);
      @(posedge CLK);
    end
    @(negedge CLK); RESET = 1'b0; dq_oe = 1'b0;
    model_reset();
    mdl_mem[maddr(6, 4, 0)] = d0;
    $display("write aborted by reset after beat 0");
    cmd(C_ACT, 3'd6, 15'h0006);
    rd(3'd6, 4, 1'b0);
    // PRE to the bursting bank and ACT elsewhere do not abort bursts
    cmd(C_ACT, 3'd4, 15'h0077);
    do_read(3'd4, 5, 1'b0, 1'b0, 2, C_PRE, 3'd4, 15'd0);
    do_write(3'd6, 7, 1'b0, {$urandom, $urandom}, 8'h00, 1'b0, 3, C_ACT, 3'd2, 15'h0099);
    rd(3'd6, 4, 1'b0);
    check_row(3'd2);
  endtask

  initial begin
    idle_pins();
    model_reset();
    test_reset();
    test_basic();
    test_wrap();
    test_mask();
    test_random();
    test_busy_reject();
    test_closed_bank();
    test_act_ref();
    test_ap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time=%0t limit=500000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ddr_cmd_responder.md
DDR_CMD_RESPONDER -- requirements
Module: ddr_cmd_responder

Interface
REQ-001 Parameters SHALL be:
- CL, 5, read latency in CLK cycles from READ command to first read beat.
- CWL, 5, write latency in CLK cycles from WRITE command to first write beat.
- COL_BITS, 3, column bits used for storage addressing; storage is 8 banks x 2^COL_BITS words x 16 bits.

REQ-002 Ports SHALL be:
- CLK  in  1  single clock; all sequential logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CS, RAS, CAS, WE  in  1 each  active-low command pins.
- Addr  in  15  row on ACT; column in [9:0], A10 = auto-precharge / all-banks flag.
- BA  in  3  bank address.
- LDM, UDM  in  1 each  write mask for DQ[7:0] and DQ[15:8]; 1 = byte not written.
- DQ  inout  16  write data in, read data out.
- LDQS, UDQS  inout  1 each  read strobes.
- bank_open  out  8  per-bank open flag.
- open_row  out  15  row latched for the bank currently selected by BA.
- cmd_err  out  1  sticky protocol-error flag.
- busy  out  1  burst scheduled or in progress.

Function
REQ-003 The block SHALL decode {CS,RAS,CAS,WE} on every CLK edge:
- 1xxx or 0111 = NOP
- 0011 = ACT
- 0101 = READ
- 0100 = WRITE
- 0010 = PRE
- 0001 = REF
- 0000 = MRS
- 0110 = ZQCL
REQ-004 MRS and ZQCL SHALL be accepted with no state change.
REQ-005 ACT SHALL set bank_open[BA] and latch Addr as that bank's row; ACT to an already-open bank SHALL set cmd_err and be ignored.
REQ-006 PRE with A10=0 SHALL clear bank_open[BA]; PRE with A10=1 SHALL clear all eight flags; PRE to a closed bank is legal.
REQ-007 REF while any bank is open SHALL set cmd_err; otherwise REF is a no-op.
REQ-008 READ/WRITE to a closed bank, or issued while busy=1, SHALL set cmd_err and be ignored.
REQ-009 The FSM SHALL have states IDLE, WLAT, WBURST, RLAT, RBURST, with a latency counter and a 2-bit beat counter:
- IDLE -> WLAT on an accepted WRITE.
- IDLE -> RLAT on an accepted READ.
- WLAT -> WBURST after CWL-1 cycles.
- RLAT -> RBURST after CL-1 cycles.
- WBURST/RBURST -> IDLE after beat 3.
REQ-010 busy SHALL be 1 in every state except IDLE.
REQ-011 Burst length SHALL be 4 beats, one per CLK.
REQ-012 The storage address of beat n SHALL be {BA, col[COL_BITS-1:2], (col[1:0]+n) mod 4}: sequential wrap within an aligned group of 4.
REQ-013 Bank, column and A10 SHALL be latched at the command edge; later command-pin activity SHALL NOT alter an in-flight burst.
REQ-014 Write beats SHALL sample DQ, LDM and UDM on the rising edge exactly CWL cycles after the WRITE edge, and on the 3 following edges; masked bytes SHALL keep their prior contents.
REQ-015 Read beat 0 SHALL drive DQ valid exactly CL cycles after the READ edge; DQ SHALL hold each beat for one full cycle.
REQ-016 LDQS and UDQS SHALL be driven 0 in the cycle before beat 0 (preamble), then 1, 0, 1, 0 on beats 0-3, and released after beat 3.
REQ-017 DQ, LDQS and UDQS SHALL be high-Z whenever no read preamble or beat is being driven.
REQ-018 A READ/WRITE with A10=1 SHALL clear bank_open for its bank on the cycle after beat 3.
REQ-019 An ACT or PRE arriving during a burst SHALL be processed normally and SHALL NOT abort the burst.
REQ-020 A PRE to the bursting bank SHALL NOT abort the burst; the data transfer completes.
REQ-021 cmd_err SHALL stay set until RESET.

Reset
REQ-022 While RESET=1 the block SHALL hold:
- bank_open=0, open_row=0, cmd_err=0, busy=0
- FSM=IDLE
- DQ, LDQS, UDQS high-Z
REQ-023 Storage contents SHALL NOT be reset.
REQ-024 RESET asserted mid-burst SHALL abort the burst immediately, release the bus asynchronously, and leave beats not yet written unwritten.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- ACT BA=5 row=1; WRITE BA=5 col=1, data 0x00A1,00A2,00A3,00A4 at +5..+8; READ BA=5 col=1 -> DQ shows 0x00A1..00A4 at +5..+8, LDQS 0 at +4 then 1,0,1,0.
- WRITE col=2 after ACT -> beat order addresses 2,3,0,1; a READ from col=0 returns beat 2's data first.
- WRITE with UDM=1 on all beats over prior 0xFFFF -> readback 0xFF<low byte written>.
- READ to closed bank 3 -> cmd_err=1, DQ stays high-Z, busy stays 0.
- ACT on open bank, then REF with a bank open -> cmd_err=1 after the first; PRE A10=1 -> bank_open=0x00.
- READ with A10=1 -> bank_open[BA] clears the cycle after beat 3; RESET at beat 1 -> DQ high-Z, busy=0, cmd_err=0.
